// File: rtl/line_fetch.sv
// Framebuffer line fetcher: on each line request, streams one line of LEN reads
// and raises a linebuffer write enable aligned with the returning read data.
module line_fetch #(
  parameter int LEN    = 640,
  parameter int LINES  = 480,
  parameter int RD_LAT = 1,
  parameter int ADDRW  = $clog2(LEN * LINES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     line_req,
  output logic                     fb_rd,
  output logic [ADDRW-1:0]         fb_addr,
  output logic                     en_wr,
  output logic                     busy,
  output logic [$clog2(LINES)-1:0] line_num,
  output logic                     overrun
);

  localparam int CW  = $clog2(LEN);
  localparam int LNW = $clog2(LINES);

  localparam logic [CW-1:0]    RD_LAST    = CW'(LEN - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);
  localparam logic [LNW-1:0]   LINE_LAST  = LNW'(LINES - 1);
  localparam logic [ADDRW-1:0] LINE_STEP  = ADDRW'(LEN);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state;
  logic [CW-1:0]      rd_cnt;
  logic [1:0]         drain_cnt;
  logic [ADDRW-1:0]   base;
  logic [RD_LAT-1:0]  rd_pipe;

  assign en_wr = rd_pipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fb_rd     <= 1'b0;
      fb_addr   <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      line_num  <= '0;
      base      <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      rd_pipe   <= '0;
    end else begin
      overrun    <= 1'b0;
      rd_pipe[0] <= fb_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      if (frame_start) begin
        // Restart the frame; any in-flight reads are discarded, and a coincident
        // line request becomes a fresh fetch of line 0.
        line_num  <= '0;
        base      <= '0;
        rd_pipe   <= '0;
        rd_cnt    <= '0;
        drain_cnt <= '0;
        if (line_req) begin
          state   <= FETCH;
          fb_rd   <= 1'b1;
          fb_addr <= '0;
          busy    <= 1'b1;
        end else begin
          state   <= IDLE;
          fb_rd   <= 1'b0;
          busy    <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (line_req) begin
              state   <= FETCH;
              fb_rd   <= 1'b1;
              fb_addr <= base;
              rd_cnt  <= '0;
              busy    <= 1'b1;
            end
          end
          FETCH: begin
            if (line_req) overrun <= 1'b1;
            if (rd_cnt == RD_LAST) begin
              state     <= DRAIN;
              fb_rd     <= 1'b0;
              drain_cnt <= '0;
            end else begin
              rd_cnt  <= rd_cnt + 1'b1;
              fb_addr <= fb_addr + 1'b1;
            end
          end
          DRAIN: begin
            if (line_req) overrun <= 1'b1;
            if (drain_cnt == DRAIN_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (line_num == LINE_LAST) begin
                line_num <= '0;
                base     <= '0;
              end else begin
                line_num <= line_num + 1'b1;
                base     <= base + LINE_STEP;
              end
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            fb_rd <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_fetch.sv
// Scoreboard bench for line_fetch (LEN=4, LINES=3, RD_LAT=2): stimulus queues
// expected read/write/overrun events, a negedge monitor pops and compares them.
module tb_line_fetch;

  localparam int LEN    = 4;
  localparam int LINES  = 3;
  localparam int RD_LAT = 2;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       line_req;
  logic       fb_rd;
  logic [3:0] fb_addr;
  logic       en_wr;
  logic       busy;
  logic [1:0] line_num;
  logic       overrun;

  typedef struct {
    int cyc;
    int addr;
  } rd_t;

  rd_t rd_q[$];
  int  wr_q[$];
  int  ov_q[$];

  int  cyc;
  int  n_cmp;
  int  n_fail;
  rd_t mon_rd;
  int  mon_cyc;

  line_fetch #(
    .LEN(LEN),
    .LINES(LINES),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .line_req(line_req),
    .fb_rd(fb_rd),
    .fb_addr(fb_addr),
    .en_wr(en_wr),
    .busy(busy),
    .line_num(line_num),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fs, input logic lr, output int c0);
    c0          = cyc;
    frame_start = fs;
    line_req    = lr;
    step();
    frame_start = 1'b0;
    line_req    = 1'b0;
  endtask

  task automatic pushFetch(input int c0, input int line, input int nrd, input int nwr);
    for (int i = 0; i < nrd; i++) begin
      rd_q.push_back('{cyc: c0 + 1 + i, addr: line * LEN + i});
    end
    for (int i = 0; i < nwr; i++) begin
      wr_q.push_back(c0 + 1 + RD_LAT + i);
    end
  endtask

  // Monitor: every read strobe, write enable and overrun pulse must match the
  // next expected event in its queue, by cycle (and address for reads).
  always @(negedge clk) begin
    if (fb_rd === 1'b1) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected_fb_rd", cyc, -1);
      end else begin
        mon_rd = rd_q.pop_front();
        checkOutput("fb_rd_cycle", cyc, mon_rd.cyc);
        checkOutput("fb_addr", int'(fb_addr), mon_rd.addr);
      end
    end
    if (en_wr === 1'b1) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_en_wr", cyc, -1);
      end else begin
        mon_cyc = wr_q.pop_front();
        checkOutput("en_wr_cycle", cyc, mon_cyc);
      end
    end
    if (overrun === 1'b1) begin
      if (ov_q.size() == 0) begin
        checkOutput("unexpected_overrun", cyc, -1);
      end else begin
        mon_cyc = ov_q.pop_front();
        checkOutput("overrun_cycle", cyc, mon_cyc);
      end
    end
  end

  initial begin
    int c0;
    int c1;
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    frame_start = 1'b0;
    line_req    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_fb_rd", int'(fb_rd), 0);
    checkOutput("reset_en_wr", int'(en_wr), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    checkOutput("reset_fb_addr", int'(fb_addr), 0);
    checkOutput("reset_line_num", int'(line_num), 0);
    rst = 1'b0;
    step();

    // Single fetch of line 0: busy for cycles 1..6, line_num advances at 7
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 0, 4, 4);
    for (int i = 1; i <= 7; i++) begin
      checkOutput("s1_busy", int'(busy), (i <= 6) ? 1 : 0);
      checkOutput("s1_line_num", int'(line_num), (i >= 7) ? 1 : 0);
      if (i < 7) step();
    end

    // Back-to-back lines 1 and 2, then wrap to line 0 at address 0
    for (int l = 1; l <= 3; l++) begin
      applyStimulus(1'b0, 1'b1, c0);
      pushFetch(c0, l % LINES, 4, 4);
      repeat (6) step();
      checkOutput("s2_busy_done", int'(busy), 0);
      checkOutput("s2_line_num", int'(line_num), (l + 1) % LINES);
    end

    // Line request during a fetch of line 1 is dropped with an overrun pulse
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 1, 4, 4);
    step();
    ov_q.push_back(c0 + 3);
    applyStimulus(1'b0, 1'b1, c1);
    checkOutput("s3_busy", int'(busy), 1);
    repeat (4) step();
    checkOutput("s3_busy_done", int'(busy), 0);
    checkOutput("s3_line_num", int'(line_num), 2);
    step();
    checkOutput("s3_still_idle", int'(busy), 0);

    // frame_start with line_req during line 2 restarts at line 0, address 0
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 2, 2, 0);
    step();
    pushFetch(c0 + 2, 0, 4, 4);
    applyStimulus(1'b1, 1'b1, c1);
    checkOutput("s5_fb_rd", int'(fb_rd), 1);
    checkOutput("s5_fb_addr", int'(fb_addr), 0);
    checkOutput("s5_line_num", int'(line_num), 0);
    repeat (6) step();
    checkOutput("s5_busy_done", int'(busy), 0);
    checkOutput("s5_line_num_after", int'(line_num), 1);

    // frame_start at the second read of line 1 aborts the fetch
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 1, 2, 0);
    step();
    applyStimulus(1'b1, 1'b0, c1);
    checkOutput("s4_fb_rd", int'(fb_rd), 0);
    checkOutput("s4_en_wr", int'(en_wr), 0);
    checkOutput("s4_busy", int'(busy), 0);
    checkOutput("s4_line_num", int'(line_num), 0);
    checkOutput("s4_overrun", int'(overrun), 0);
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 0, 4, 4);
    repeat (6) step();
    checkOutput("s4_line_num_after", int'(line_num), 1);

    // Reset in the middle of DRAIN kills the last write enable
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 1, 4, 3);
    repeat (4) step();
    rst = 1'b1;
    step();
    checkOutput("s6_en_wr", int'(en_wr), 0);
    checkOutput("s6_fb_rd", int'(fb_rd), 0);
    checkOutput("s6_busy", int'(busy), 0);
    checkOutput("s6_overrun", int'(overrun), 0);
    checkOutput("s6_fb_addr", int'(fb_addr), 0);
    checkOutput("s6_line_num", int'(line_num), 0);
    rst = 1'b0;
    step();
    checkOutput("s6_en_wr_after", int'(en_wr), 0);
    checkOutput("s6_busy_after", int'(busy), 0);
    applyStimulus(1'b0, 1'b1, c0);
    pushFetch(c0, 0, 4, 4);
    repeat (6) step();
    checkOutput("s6_line_num_after", int'(line_num), 1);

    repeat (3) step();
    checkOutput("rd_events_left", rd_q.size(), 0);
    checkOutput("wr_events_left", wr_q.size(), 0);
    checkOutput("ov_events_left", ov_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL have parameter LEN, default 640: pixels per line, i.e. reads per fetch (>=2).
REQ-002 SHALL have parameter LINES, default 480: lines per frame (>=2).
REQ-003 SHALL have parameter RD_LAT, default 1: framebuffer read latency in cycles (1..3).
REQ-004 SHALL have parameter ADDRW, default $clog2(LEN*LINES): framebuffer address width.
REQ-005 SHALL have port clk  input  1  system clock; single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port frame_start  input  1  pulse: restart at line 0.
REQ-008 SHALL have port line_req  input  1  pulse: fetch next line (linebuffer data request).
REQ-009 SHALL have port fb_rd  output  1  framebuffer read strobe.
REQ-010 SHALL have port fb_addr  output  ADDRW  framebuffer read address.
REQ-011 SHALL have port en_wr  output  1  linebuffer write enable, aligned with returning read data.
REQ-012 SHALL have port busy  output  1  fetch or pipeline drain in progress.
REQ-013 SHALL have port line_num  output  $clog2(LINES)  line the next fetch reads.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse: line_req dropped.

Function
REQ-015 SHALL implement states IDLE, FETCH and DRAIN.
REQ-016 SHALL move IDLE->FETCH on line_req; first fb_rd cycle is the cycle after line_req, with fb_addr = line_num*LEN.
REQ-017 SHALL, in FETCH, assert fb_rd for exactly LEN consecutive cycles, incrementing fb_addr by 1 each cycle.
REQ-018 SHALL move FETCH->DRAIN after the LENth read; DRAIN lasts RD_LAT cycles, then IDLE.
REQ-019 SHALL drive en_wr as fb_rd delayed by exactly RD_LAT cycles, giving exactly LEN en_wr cycles per fetch.
REQ-020 SHALL assert busy from the first fb_rd cycle through the last en_wr cycle inclusive; busy low in IDLE.
REQ-021 SHALL hold the line base address in a register, advanced by LEN on fetch completion with no multiplier.
REQ-022 SHALL increment line_num on the final DRAIN cycle; line LINES-1 wraps to 0 and the base to 0.
REQ-023 SHALL drop a line_req received while busy, pulse overrun the following cycle, and leave the state unchanged.
REQ-024 SHALL, on frame_start in IDLE, set line_num and base to 0 the next cycle.
REQ-025 SHALL, on frame_start in FETCH or DRAIN, abort: fb_rd and en_wr low the next cycle, read pipeline flushed, state IDLE, line_num 0, no overrun.
REQ-026 SHALL treat frame_start with line_req in the same cycle as a frame restart followed by a line-0 fetch starting the next cycle.
REQ-027 SHALL apply priority rst > frame_start > line_req.
REQ-028 SHALL hold fb_addr at its last value when fb_rd is low.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, fb_rd=0, en_wr=0, busy=0, overrun=0, fb_addr=0, line_num=0, base=0 and clear the delay pipeline.
REQ-030 SHALL abort any fetch when rst is asserted mid-operation, with no en_wr after the reset cycle.

Verification
All scenarios use LEN=4, LINES=3, RD_LAT=2.
REQ-031 SHALL cover: rst, then line_req at cycle 0 -> fb_rd cycles 1-4 with addr 0,1,2,3; en_wr cycles 3-6; busy cycles 1-6; line_num=1 from cycle 7.
REQ-032 SHALL cover: three back-to-back fetches -> base addresses 0, 4, 8; line_num then 0, and the fourth fetch reads from addr 0.
REQ-033 SHALL cover: line_req at cycle 2 of a fetch -> overrun pulse at cycle 3; exactly 4 fb_rd and 4 en_wr cycles; line_num +1 only.
REQ-034 SHALL cover: frame_start at the second fb_rd cycle of line 1 -> fb_rd=0 and en_wr=0 next cycle; busy=0; line_num=0; next fetch reads addr 0.
REQ-035 SHALL cover: frame_start with line_req in the same cycle during line 2 -> fetch of line 0 starts next cycle at addr 0.
REQ-036 SHALL cover: rst during DRAIN -> en_wr=0 from the next cycle; all outputs at reset values; line_num=0.
